// File: rtl/alu_issue_ctrl_if.sv
// Bundles the instruction handshake, ALU drive/capture, host write and debug
// signals of the ALU issue controller.
interface alu_issue_ctrl_if #(
  parameter int AW = 2,
  parameter int DW = 8
);
  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    instr;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [DW-1:0] alu_out;
  logic          alu_zero;
  logic          host_we;
  logic [AW-1:0] host_waddr;
  logic [DW-1:0] host_wdata;
  logic [AW-1:0] dbg_raddr;
  logic [DW-1:0] dbg_rdata;
  logic          done;
  logic [DW-1:0] result;
  logic          zero_flag;

  modport slave (
    input  instr_valid, instr, alu_out, alu_zero,
           host_we, host_waddr, host_wdata, dbg_raddr,
    output instr_ready, alu_op, alu_in1, alu_in2, dbg_rdata,
           done, result, zero_flag
  );

  modport master (
    output instr_valid, instr, alu_out, alu_zero,
           host_we, host_waddr, host_wdata, dbg_raddr,
    input  instr_ready, alu_op, alu_in1, alu_in2, dbg_rdata,
           done, result, zero_flag
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts instruction words, drives the external ALU
// from the register file and writes the captured result back.
module alu_issue_ctrl #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_ctrl_if.slave    bus
);
  localparam int unsigned NREG = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_ready;
  logic          w_accept;
  logic          w_alu_wr;

  logic [DW-1:0] r_rf [NREG];
  logic [1:0]    r_ra;
  logic          r_wb;
  logic [2:0]    r_alu_op;
  logic [DW-1:0] r_alu_in1;
  logic [DW-1:0] r_alu_in2;
  logic [DW-1:0] r_result;
  logic          r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.instr_valid) w_next = S_ISSUE;
      end
      S_ISSUE: w_next = S_DONE;
      S_DONE: begin
        w_ready = 1'b1;
        w_next  = bus.instr_valid ? S_ISSUE : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = bus.instr_valid & w_ready;
  assign w_alu_wr = (r_state == S_ISSUE) & r_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra      <= '0;
      r_wb      <= 1'b0;
      r_alu_op  <= '0;
      r_alu_in1 <= '0;
      r_alu_in2 <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ra      <= bus.instr[4:3];
        r_wb      <= bus.instr[0];
        r_alu_op  <= bus.instr[7:5];
        r_alu_in1 <= r_rf[bus.instr[4:3]];
        r_alu_in2 <= r_rf[bus.instr[2:1]];
      end
      if (r_state == S_ISSUE) begin
        r_result <= bus.alu_out;
        r_zero   <= bus.alu_zero;
      end
    end
  end

  // ALU writeback takes priority over a host write to the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (w_alu_wr && r_ra == 2'(i))
          r_rf[i] <= bus.alu_out;
        else if (bus.host_we && bus.host_waddr == AW'(i))
          r_rf[i] <= bus.host_wdata;
      end
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.alu_op      = r_alu_op;
  assign bus.alu_in1     = r_alu_in1;
  assign bus.alu_in2     = r_alu_in2;
  assign bus.dbg_rdata   = r_rf[bus.dbg_raddr];
  assign bus.done        = (r_state == S_DONE);
  assign bus.result      = r_result;
  assign bus.zero_flag   = r_zero;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized
// instructions checked against a register-file/latency reference model.
module tb_alu_issue_ctrl;
  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;

  logic [7:0] m_rf [4];

  alu_issue_ctrl_if #(.AW(2), .DW(8)) bus ();

  alu_issue_ctrl #(.AW(2), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    return a + 8'd1;
      3'd1:    return a - 8'd1;
      3'd2:    return a ^ b;
      3'd3:    return a & b;
      3'd4:    return a << b;
      3'd5:    return a | b;
      3'd6:    return a + b;
      default: return a - b;
    endcase
  endfunction

  // External combinational ALU
  assign bus.alu_out  = alu_f(bus.alu_op, bus.alu_in1, bus.alu_in2);
  assign bus.alu_zero = (bus.alu_out == 8'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    bus.host_we    = 1'b1;
    bus.host_waddr = a;
    bus.host_wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.host_we = 1'b0;
    m_rf[a] = d;
  endtask

  task automatic rd_rf(input logic [1:0] a, output logic [7:0] d);
    bus.dbg_raddr = a;
    #1;
    d = bus.dbg_rdata;
  endtask

  // Issue one instruction from an idle negedge; optionally host-write on T1.
  task automatic issue(input logic [7:0] ins, input bit hw,
                       input logic [1:0] ha, input logic [7:0] hd);
    logic [2:0] op;
    logic [1:0] ra, rb;
    logic       wb;
    logic [7:0] ea, eb, er;
    op = ins[7:5]; ra = ins[4:3]; rb = ins[2:1]; wb = ins[0];
    ea = m_rf[ra]; eb = m_rf[rb]; er = alu_f(op, ea, eb);
    check("ready_idle", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("ready_issue", 32'(bus.instr_ready), 32'd0);
    check("done_issue", 32'(bus.done), 32'd0);
    check("alu_op", 32'(bus.alu_op), 32'(op));
    check("alu_in1", 32'(bus.alu_in1), 32'(ea));
    check("alu_in2", 32'(bus.alu_in2), 32'(eb));
    if (hw) begin
      bus.host_we    = 1'b1;
      bus.host_waddr = ha;
      bus.host_wdata = hd;
    end
    @(posedge clk);
    @(negedge clk);
    bus.host_we = 1'b0;
    if (wb) m_rf[ra] = er;
    if (hw && !(wb && ha == ra)) m_rf[ha] = hd;
    check("done_pulse", 32'(bus.done), 32'd1);
    check("result", 32'(bus.result), 32'(er));
    check("zero_flag", 32'(bus.zero_flag), 32'(er == 8'd0));
    check("alu_in1_hold", 32'(bus.alu_in1), 32'(ea));
    @(posedge clk);
    @(negedge clk);
    check("done_end", 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] a;
    n_err = 0;
    n_chk = 0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.host_we     = 1'b0;
    bus.host_waddr  = '0;
    bus.host_wdata  = '0;
    bus.dbg_raddr   = '0;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;

    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_zero", 32'(bus.zero_flag), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_in1", 32'(bus.alu_in1), 32'd0);
    check("rst_in2", 32'(bus.alu_in2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_rf(2'(i), d);
      check("rst_rf", 32'(d), 32'd0);
    end

    // 1: inc r0
    host_wr(2'd0, 8'd5);
    issue(8'h01, 1'b0, 2'd0, 8'd0);
    check("t1_result", 32'(bus.result), 32'd6);
    check("t1_zero", 32'(bus.zero_flag), 32'd0);
    rd_rf(2'd0, d);
    check("t1_rf0", 32'(d), 32'd6);

    // 2: xor r1,r2 -> zero
    host_wr(2'd1, 8'h3C);
    host_wr(2'd2, 8'h3C);
    issue(8'h4D, 1'b0, 2'd0, 8'd0);
    check("t2_result", 32'(bus.result), 32'd0);
    check("t2_zero", 32'(bus.zero_flag), 32'd1);
    rd_rf(2'd1, d);
    check("t2_rf1", 32'(d), 32'd0);

    // 3: back-to-back inc r0 with valid held
    host_wr(2'd0, 8'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = 8'h01;
    @(posedge clk);
    @(negedge clk);
    check("t3_in1_a", 32'(bus.alu_in1), 32'd1);
    check("t3_ready_issue", 32'(bus.instr_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t3_done_a", 32'(bus.done), 32'd1);
    check("t3_res_a", 32'(bus.result), 32'd2);
    check("t3_ready_done", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("t3_done_gap", 32'(bus.done), 32'd0);
    check("t3_in1_b", 32'(bus.alu_in1), 32'd2);
    @(posedge clk);
    @(negedge clk);
    check("t3_done_b", 32'(bus.done), 32'd1);
    check("t3_res_b", 32'(bus.result), 32'd3);
    @(posedge clk);
    @(negedge clk);
    check("t3_done_end", 32'(bus.done), 32'd0);
    rd_rf(2'd0, d);
    check("t3_rf0", 32'(d), 32'd3);
    m_rf[0] = 8'd3;

    // 4: writeback vs host collision on T1
    host_wr(2'd3, 8'd9);
    issue(8'h39, 1'b1, 2'd3, 8'h77);
    rd_rf(2'd3, d);
    check("t4_rf3", 32'(d), 32'd8);
    issue(8'h39, 1'b1, 2'd2, 8'h11);
    rd_rf(2'd2, d);
    check("t4_rf2", 32'(d), 32'h11);
    rd_rf(2'd3, d);
    check("t4_rf3b", 32'(d), 32'd7);

    // 5: shift, no writeback
    host_wr(2'd0, 8'd1);
    host_wr(2'd1, 8'd3);
    issue(8'h82, 1'b0, 2'd0, 8'd0);
    check("t5_result", 32'(bus.result), 32'd8);
    rd_rf(2'd0, d);
    check("t5_rf0", 32'(d), 32'd1);

    // Randomized instructions against the model
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        host_wr(2'($urandom), 8'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) @(negedge clk);
      issue(8'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
      a = 2'($urandom);
      rd_rf(a, d);
      check("rnd_rf", 32'(d), 32'(m_rf[a]));
    end

    // 6: reset during ISSUE
    host_wr(2'd0, 8'h40);
    bus.instr_valid = 1'b1;
    bus.instr       = 8'h01;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_done", 32'(bus.done), 32'd0);
    check("t6_result", 32'(bus.result), 32'd0);
    check("t6_zero", 32'(bus.zero_flag), 32'd0);
    check("t6_alu_op", 32'(bus.alu_op), 32'd0);
    check("t6_in1", 32'(bus.alu_in1), 32'd0);
    check("t6_in2", 32'(bus.alu_in2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_rf(2'(i), d);
      check("t6_rf", 32'(d), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_ready", 32'(bus.instr_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_done", 32'(bus.done), 32'd0);
    end
    rd_rf(2'd0, d);
    check("t6_rf0_after", 32'(d), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
